// File: rtl/reg_dump_scanner_pkg.sv
// Shared definitions for the register-dump scanner: default geometry, the
// settle counter width and the scanner FSM state encoding.
// No logic, no ports.
package reg_dump_scanner_pkg;

  localparam int NREGS_DEF  = 16;
  localparam int IDX_W_DEF  = 4;
  localparam int DATA_W_DEF = 16;
  localparam int SETTLE_DEF = 1;
  // SETTLE ranges 0..15
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } scan_state_t;

endpackage

// File: rtl/reg_dump_scanner_settle_timer.sv
// Purpose: loadable down-counter that spaces register-file reads; flags zero.
// Latency: load/decrement take effect on the next rising edge; o_zero is combinational from the count.
// Backpressure: none; the caller decides when to load or decrement.
// Ports: i_clk, i_reset (async active-low), i_load/i_load_val (load has priority),
//        i_dec (decrement by one), o_zero (count is zero).
module reg_dump_scanner_settle_timer
  import reg_dump_scanner_pkg::*;
#(
  parameter int CW = CNT_W
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/reg_dump_scanner.sv
// Purpose: drives the register file debug index and streams (index, data) beats, sweep or single.
// Latency: first beat valid SETTLE+1 edges after start accept; SETTLE+2 cycles per beat at full rate.
// Backpressure: o_dump_valid held with stable idx/data (and o_inr) until i_dump_ready; i_enable=0 freezes all.
// Ports: i_clk, i_reset (async active-low), i_enable, i_start, i_mode, i_sel_idx,
//        o_inr/i_outvalue (register file read port), o_dump_valid/i_dump_ready/o_dump_idx/o_dump_data,
//        o_busy, o_done.
module reg_dump_scanner
  import reg_dump_scanner_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [IDX_W-1:0]  i_sel_idx,
  output logic [IDX_W-1:0]  o_inr,
  input  logic [DATA_W-1:0] i_outvalue,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [IDX_W-1:0]  o_dump_idx,
  output logic [DATA_W-1:0] o_dump_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);
  localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE);

  scan_state_t       r_state;
  scan_state_t       w_nxt;
  logic [IDX_W-1:0]  r_inr;
  logic              r_single;
  logic              r_dump_valid;
  logic [IDX_W-1:0]  r_dump_idx;
  logic [DATA_W-1:0] r_dump_data;
  logic              r_busy;

  logic w_accept;
  logic w_load;
  logic w_dec;
  logic w_capture;
  logic w_beat_done;
  logic w_advance;
  logic w_finish;
  logic w_cnt_zero;

  reg_dump_scanner_settle_timer #(.CW(CNT_W)) u_settle (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (SETTLE_V),
    .i_dec      (w_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Every strobe is qualified by i_enable here, so a frozen cycle leaves
  // the state, the counter and every output register untouched.
  always_comb begin
    w_nxt       = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_capture   = 1'b0;
    w_beat_done = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    if (i_enable) begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_accept = 1'b1;
            w_load   = 1'b1;
            w_nxt    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!w_cnt_zero) begin
            w_dec = 1'b1;
          end else begin
            w_capture = 1'b1;
            w_nxt     = ST_SEND;
          end
        end
        ST_SEND: begin
          if (r_dump_valid && i_dump_ready) begin
            w_beat_done = 1'b1;
            // Comparing against the last index rather than wrapping keeps
            // the sweep from ever running past r(NREGS-1).
            if (r_single || (r_inr == LAST_IDX)) begin
              w_nxt = ST_DONE;
            end else begin
              w_advance = 1'b1;
              w_load    = 1'b1;
              w_nxt     = ST_WAIT;
            end
          end
        end
        ST_DONE: begin
          w_finish = 1'b1;
          w_nxt    = ST_IDLE;
        end
        default: w_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_inr        <= '0;
      r_single     <= 1'b0;
      r_dump_valid <= 1'b0;
      r_dump_idx   <= '0;
      r_dump_data  <= '0;
      r_busy       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_inr    <= i_mode ? i_sel_idx : '0;
        r_single <= i_mode;
        r_busy   <= 1'b1;
      end
      if (w_capture) begin
        r_dump_data  <= i_outvalue;
        r_dump_idx   <= r_inr;
        r_dump_valid <= 1'b1;
      end
      if (w_beat_done) begin
        r_dump_valid <= 1'b0;
      end
      if (w_advance) begin
        r_inr <= r_inr + 1'b1;
      end
      if (w_finish) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_inr        = r_inr;
  assign o_dump_valid = r_dump_valid;
  assign o_dump_idx   = r_dump_idx;
  assign o_dump_data  = r_dump_data;
  assign o_busy       = r_busy;
  // Pulses in the single cycle the FSM actually executes DONE.
  assign o_done       = w_finish;

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Bench for reg_dump_scanner with a behavioural register file (async read)
// preloaded with r_i = 16'hA000 + i; directed scenarios with hand-computed expectations.
module tb_reg_dump_scanner;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        i_start;
  logic        i_mode;
  logic [3:0]  i_sel_idx;
  logic [3:0]  o_inr;
  logic [15:0] w_outvalue;
  logic        o_dump_valid;
  logic        i_dump_ready;
  logic [3:0]  o_dump_idx;
  logic [15:0] o_dump_data;
  logic        o_busy;
  logic        o_done;

  logic [15:0] regs [16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign w_outvalue = regs[o_inr];

  reg_dump_scanner #(
    .NREGS  (16),
    .IDX_W  (4),
    .DATA_W (16),
    .SETTLE (1)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_start      (i_start),
    .i_mode       (i_mode),
    .i_sel_idx    (i_sel_idx),
    .o_inr        (o_inr),
    .i_outvalue   (w_outvalue),
    .o_dump_valid (o_dump_valid),
    .i_dump_ready (i_dump_ready),
    .o_dump_idx   (o_dump_idx),
    .o_dump_data  (o_dump_data),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_dump_valid && n < max);
    if (!o_dump_valid) check_eq("valid_timeout", {31'd0, o_dump_valid}, 32'd1);
  endtask

  // gap = edges expected from the current point until the beat becomes visible (0 = don't check)
  task automatic expect_beat(input string tag, input int k, input logic [15:0] d, input int gap);
    int n;
    wait_valid(20, n);
    if (gap > 0) check_eq({tag, "_gap"}, n, gap);
    check_eq({tag, "_idx"}, {28'd0, o_dump_idx}, k);
    check_eq({tag, "_data"}, {16'd0, o_dump_data}, {16'd0, d});
    check_eq({tag, "_inr"}, {28'd0, o_inr}, k);
  endtask

  task automatic start_dump(input logic m, input logic [3:0] s);
    i_mode    = m;
    i_sel_idx = s;
    i_start   = 1'b1;
    tick();
    i_start   = 1'b0;
    check_eq("start_busy", {31'd0, o_busy}, 32'd1);
  endtask

  // Called with the last beat visible and ready high.
  task automatic finish_dump(input string tag);
    tick();
    check_eq({tag, "_done"}, {31'd0, o_done}, 32'd1);
    check_eq({tag, "_valid_off"}, {31'd0, o_dump_valid}, 32'd0);
    tick();
    check_eq({tag, "_done_off"}, {31'd0, o_done}, 32'd0);
    check_eq({tag, "_busy_off"}, {31'd0, o_busy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_inr"}, {28'd0, o_inr}, 32'd0);
    check_eq({tag, "_valid"}, {31'd0, o_dump_valid}, 32'd0);
    check_eq({tag, "_idx"}, {28'd0, o_dump_idx}, 32'd0);
    check_eq({tag, "_data"}, {16'd0, o_dump_data}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, o_done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, expected end of test");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int seen;
    for (int i = 0; i < 16; i++) regs[i] = 16'hA000 + 16'(i);
    i_reset      = 1'b0;
    i_enable     = 1'b1;
    i_start      = 1'b0;
    i_mode       = 1'b0;
    i_sel_idx    = 4'd0;
    i_dump_ready = 1'b1;

    // 1: reset held, start toggling has no effect
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      i_start = ~i_start;
      tick();
      if (o_busy) seen++;
    end
    check_all_zero("rst");
    check_eq("rst_busy_hist", seen, 0);
    i_start = 1'b0;
    i_reset = 1'b1;
    tick();
    tick();
    check_all_zero("rst_rel");

    // 2: full sweep at full rate
    start_dump(1'b0, 4'd0);
    for (int k = 0; k < 16; k++)
      expect_beat("sweep", k, 16'hA000 + 16'(k), (k == 0) ? 2 : 3);
    finish_dump("sweep");

    // 3: single register
    start_dump(1'b1, 4'd7);
    i_mode = 1'b0;
    expect_beat("single", 7, 16'hA007, 2);
    finish_dump("single");
    check_eq("single_inr_hold", {28'd0, o_inr}, 32'd7);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (o_dump_valid || o_busy) seen++;
    end
    check_eq("single_no_extra", seen, 0);

    // 4: backpressure at beat 3
    start_dump(1'b0, 4'd0);
    for (int k = 0; k < 4; k++)
      expect_beat("bp", k, 16'hA000 + 16'(k), (k == 0) ? 2 : 3);
    i_dump_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq("bp_hold_valid", {31'd0, o_dump_valid}, 32'd1);
      check_eq("bp_hold_idx", {28'd0, o_dump_idx}, 32'd3);
      check_eq("bp_hold_data", {16'd0, o_dump_data}, 32'h0000A003);
      check_eq("bp_hold_inr", {28'd0, o_inr}, 32'd3);
    end
    i_dump_ready = 1'b1;
    tick();
    check_eq("bp_accept", {31'd0, o_dump_valid}, 32'd0);
    expect_beat("bp", 4, 16'hA004, 2);
    for (int k = 5; k < 16; k++)
      expect_beat("bp", k, 16'hA000 + 16'(k), 3);
    finish_dump("bp");

    // 5: freeze mid-sweep, start while busy, write before beat 5
    start_dump(1'b0, 4'd0);
    for (int k = 0; k < 4; k++)
      expect_beat("frz", k, 16'hA000 + 16'(k), (k == 0) ? 2 : 3);
    i_enable = 1'b0;
    i_start  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_eq("frz_valid", {31'd0, o_dump_valid}, 32'd1);
      check_eq("frz_idx", {28'd0, o_dump_idx}, 32'd3);
      check_eq("frz_inr", {28'd0, o_inr}, 32'd3);
      check_eq("frz_busy", {31'd0, o_busy}, 32'd1);
      check_eq("frz_done", {31'd0, o_done}, 32'd0);
    end
    i_enable = 1'b1;
    i_start  = 1'b0;
    regs[5]  = 16'h1234;
    expect_beat("frz", 4, 16'hA004, 3);
    i_start = 1'b1;
    expect_beat("frz", 5, 16'h1234, 3);
    i_start = 1'b0;
    for (int k = 6; k < 16; k++)
      expect_beat("frz", k, 16'hA000 + 16'(k), 3);
    finish_dump("frz");
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (o_dump_valid || o_busy) seen++;
    end
    check_eq("frz_idle_after", seen, 0);
    regs[5] = 16'hA005;

    // 6: reset during beat 9, then restart from index 0
    start_dump(1'b0, 4'd0);
    for (int k = 0; k < 10; k++)
      expect_beat("mrst", k, 16'hA000 + 16'(k), (k == 0) ? 2 : 3);
    i_reset = 1'b0;
    #1;
    check_all_zero("mrst_async");
    seen = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (o_done || o_busy || o_dump_valid) seen++;
    end
    check_eq("mrst_quiet", seen, 0);
    i_reset = 1'b1;
    tick();
    start_dump(1'b0, 4'd0);
    for (int k = 0; k < 16; k++)
      expect_beat("restart", k, 16'hA000 + 16'(k), (k == 0) ? 2 : 3);
    finish_dump("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
